// File: rtl/ect_meas_sequencer.sv
// ECT measurement sequencer: excitation enable, Sync square wave, period/measurement/frame
// counters and the ADC req/ack handshake. Define SEQ_ACK_TIMEOUT_EN to add the ack timeout.
module ect_meas_sequencer #(
  parameter int unsigned SYNC_DIV = 1000,
  parameter int unsigned PERIODS  = 8,
  parameter int unsigned SETTLE   = 2
`ifdef SEQ_ACK_TIMEOUT_EN
  ,
  parameter int unsigned ACK_TIMEOUT = 4095
`endif
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Abort,
  input  logic [15:0] NumFrames,
  input  logic [7:0]  MeasNum,
  output logic        EnExcit,
  output logic        Sync,
  output logic [7:0]  periodCnt,
  output logic        AdcReq,
  input  logic        AdcAck,
  output logic [7:0]  MeasIdx,
  output logic [15:0] FrameCnt,
  output logic        Busy,
  output logic        Done,
  output logic        AckErr
);

  localparam int unsigned SCW = $clog2(SYNC_DIV);
  localparam logic [SCW-1:0] SyncLast = SCW'(SYNC_DIV - 1);
  localparam logic [SCW-1:0] SyncHalf = SCW'(SYNC_DIV / 2);
  localparam logic [7:0]     PerLast  = 8'(PERIODS - 1);
  localparam logic [7:0]     SettleP  = 8'(SETTLE);

`ifdef SEQ_ACK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] ToLast = TW'(ACK_TIMEOUT - 1);
  logic [TW-1:0] to_cnt_q;
`endif

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

  state_e         state_q;
  logic [SCW-1:0] sync_cnt_q;
  logic [7:0]     meas_last_q;
  logic [15:0]    num_frames_q;

  logic [SCW-1:0] sync_nxt;
  logic           per_wrap;
  logic           meas_wrap;
  logic [15:0]    frame_inc;
  logic           last_frame;

  always_comb begin
    sync_nxt   = (sync_cnt_q == SyncLast) ? '0 : sync_cnt_q + SCW'(1);
    per_wrap   = (periodCnt == PerLast);
    meas_wrap  = per_wrap && (MeasIdx == meas_last_q);
    frame_inc  = FrameCnt + 16'd1;
    last_frame = meas_wrap && (num_frames_q != 16'd0) && (frame_inc == num_frames_q);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= StIdle;
      sync_cnt_q   <= '0;
      meas_last_q  <= 8'd0;
      num_frames_q <= 16'd0;
      EnExcit      <= 1'b0;
      Sync         <= 1'b0;
      periodCnt    <= 8'd0;
      AdcReq       <= 1'b0;
      MeasIdx      <= 8'd0;
      FrameCnt     <= 16'd0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      AckErr       <= 1'b0;
`ifdef SEQ_ACK_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else if (Abort) begin
      // FrameCnt and AckErr survive an abort so the host can read them back
      state_q    <= StIdle;
      sync_cnt_q <= '0;
      EnExcit    <= 1'b0;
      Sync       <= 1'b0;
      periodCnt  <= 8'd0;
      AdcReq     <= 1'b0;
      MeasIdx    <= 8'd0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
`ifdef SEQ_ACK_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            state_q      <= StArm;
            FrameCnt     <= 16'd0;
            AckErr       <= 1'b0;
            meas_last_q  <= (MeasNum == 8'd0) ? 8'd0 : MeasNum - 8'd1;
            num_frames_q <= NumFrames;
            EnExcit      <= 1'b1;
            Busy         <= 1'b1;
            sync_cnt_q   <= '0;
          end
        end
        StArm: begin
          if (sync_cnt_q == SyncLast) begin
            state_q    <= StRun;
            sync_cnt_q <= '0;
            Sync       <= 1'b1;
          end else begin
            sync_cnt_q <= sync_nxt;
          end
        end
        StRun: begin
          sync_cnt_q <= sync_nxt;
          Sync       <= (sync_nxt < SyncHalf);

          // A request still pending at the next Sync rise is abandoned, not re-issued
          if ((sync_cnt_q == '0) && AdcReq && !AdcAck) begin
            AdcReq <= 1'b0;
            AckErr <= 1'b1;
          end else if ((sync_cnt_q == '0) && (periodCnt >= SettleP)) begin
            AdcReq <= 1'b1;
`ifdef SEQ_ACK_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end else if (AdcAck) begin
            AdcReq <= 1'b0;
`ifdef SEQ_ACK_TIMEOUT_EN
          end else if (AdcReq && (to_cnt_q == ToLast)) begin
            AdcReq <= 1'b0;
            AckErr <= 1'b1;
          end else if (AdcReq) begin
            to_cnt_q <= to_cnt_q + TW'(1);
`endif
          end

          // Counters move on the Sync fall so they are stable at every Sync rise
          if (sync_cnt_q == SyncHalf) begin
            periodCnt <= per_wrap ? 8'd0 : periodCnt + 8'd1;
            if (per_wrap) begin
              MeasIdx <= meas_wrap ? 8'd0 : MeasIdx + 8'd1;
            end
            if (meas_wrap) begin
              FrameCnt <= frame_inc;
            end
            if (last_frame) begin
              state_q    <= StDone;
              sync_cnt_q <= '0;
              Done       <= 1'b1;
              EnExcit    <= 1'b0;
              Sync       <= 1'b0;
              Busy       <= 1'b0;
              AdcReq     <= 1'b0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ect_meas_sequencer.sv
// Scoreboard bench for ect_meas_sequencer: expected ADC requests and Done pulses are queued by
// the stimulus and popped by a monitor as the DUT presents them.
module tb_ect_meas_sequencer;

  localparam int unsigned SD  = 8;
  localparam int unsigned PER = 4;
  localparam int unsigned SET = 1;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [15:0] NumFrames = 16'd0;
  logic [7:0]  MeasNum = 8'd0;
  logic        AdcAck = 1'b0;
  logic        EnExcit;
  logic        Sync;
  logic [7:0]  periodCnt;
  logic        AdcReq;
  logic [7:0]  MeasIdx;
  logic [15:0] FrameCnt;
  logic        Busy;
  logic        Done;
  logic        AckErr;

  always #5 Clk = ~Clk;

  ect_meas_sequencer #(
    .SYNC_DIV (SD),
    .PERIODS  (PER),
    .SETTLE   (SET)
`ifdef SEQ_ACK_TIMEOUT_EN
    ,
    .ACK_TIMEOUT (3)
`endif
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Abort     (Abort),
    .NumFrames (NumFrames),
    .MeasNum   (MeasNum),
    .EnExcit   (EnExcit),
    .Sync      (Sync),
    .periodCnt (periodCnt),
    .AdcReq    (AdcReq),
    .AdcAck    (AdcAck),
    .MeasIdx   (MeasIdx),
    .FrameCnt  (FrameCnt),
    .Busy      (Busy),
    .Done      (Done),
    .AckErr    (AckErr)
  );

  typedef struct packed {
    logic        is_done;
    logic [7:0]  pc;
    logic [7:0]  mi;
    logic [15:0] fc;
  } ev_t;

  ev_t exp_q[$];
  int  n_run  = 0;
  int  n_fail = 0;
  bit  ack_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_req(input int pc, input int mi, input int fc);
    ev_t e;
    e.is_done = 1'b0;
    e.pc = 8'(pc);
    e.mi = 8'(mi);
    e.fc = 16'(fc);
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int fc);
    ev_t e;
    e.is_done = 1'b1;
    e.pc = 8'd0;
    e.mi = 8'd0;
    e.fc = 16'(fc);
    exp_q.push_back(e);
  endtask

  // One request per Sync period once periodCnt reaches SET, for every measurement of every frame
  task automatic push_run(input int meas, input int frames, input int fc0);
    for (int f = 0; f < frames; f++)
      for (int m = 0; m < meas; m++)
        for (int p = SET; p < PER; p++)
          push_req(p, m, fc0 + f);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    cyc(1);
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!Done && n < budget);
    check("done_seen", 32'(Done), 1);
  endtask

  task automatic wait_frame(input logic [15:0] v, input int budget, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (FrameCnt != v && n < budget);
    check("frame_reached", 32'(FrameCnt), 32'(v));
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!AdcReq && n < budget) begin
      cyc(1);
      n++;
    end
    check("req_seen", 32'(AdcReq), 1);
  endtask

  // ADC model: acknowledge two cycles after a request is seen
  initial begin
    int age;
    age = 0;
    forever begin
      @(negedge Clk);
      if (AdcAck) begin
        AdcAck = 1'b0;
        age = 0;
      end else if (ack_en && AdcReq) begin
        age++;
        if (age >= 2) AdcAck = 1'b1;
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: every AdcReq rise and every Done pulse must match the head of the queue
  initial begin
    logic req_prev;
    ev_t  e;
    req_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (AdcReq && !req_prev) begin
        if (exp_q.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL unexpected_req: got pc=%0d mi=%0d, expected no request", periodCnt,
                   MeasIdx);
        end else begin
          e = exp_q.pop_front();
          check("ev_kind_req", 32'(e.is_done), 0);
          check("req_periodCnt", 32'(periodCnt), 32'(e.pc));
          check("req_MeasIdx", 32'(MeasIdx), 32'(e.mi));
          check("req_FrameCnt", 32'(FrameCnt), 32'(e.fc));
        end
      end
      if (Done) begin
        if (exp_q.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL unexpected_done: got FrameCnt=%0d, expected no Done", FrameCnt);
        end else begin
          e = exp_q.pop_front();
          check("ev_kind_done", 32'(e.is_done), 1);
          check("done_FrameCnt", 32'(FrameCnt), 32'(e.fc));
        end
      end
      req_prev = AdcReq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;

    // Reset
    cyc(2);
    check("reset_outputs", 32'({EnExcit, Sync, periodCnt, AdcReq, MeasIdx, FrameCnt, Busy, Done,
                                AckErr}), 0);
    Rst = 1'b1;
    cyc(2);

    // One frame of two measurements, ack after two cycles
    ack_en = 1'b1;
    MeasNum = 8'd2;
    NumFrames = 16'd1;
    push_run(2, 1, 0);
    push_done(1);
    pulse_start();
    check("arm_en_busy_sync", 32'({EnExcit, Busy, Sync}), 32'b110);
    cyc(7);
    check("arm_last_cycle", 32'({EnExcit, Sync}), 32'b10);
    cyc(1);
    check("run_first_sync", 32'({Sync, periodCnt, MeasIdx}), 32'h10000);
    // Seven full periods plus the half period up to the final Sync fall
    wait_done(200, n);
    check("run_to_done_cycles", 32'(n), 61);
    check("done_enexcit", 32'(EnExcit), 0);
    cyc(1);
    check("idle_after_done", 32'({Busy, Done, EnExcit, AckErr}), 0);
    check("idle_framecnt", 32'(FrameCnt), 1);

    // Continuous run, three measurements per frame, then abort
    MeasNum = 8'd3;
    NumFrames = 16'd0;
    push_run(3, 2, 0);
    pulse_start();
    wait_frame(16'd1, 300, n);
    wait_frame(16'd2, 300, n);
    check("continuous_frame_len", 32'(n), 96);
    Abort = 1'b1;
    cyc(1);
    Abort = 1'b0;
    check("abort_outputs", 32'({EnExcit, Sync, AdcReq, Busy, Done, periodCnt, MeasIdx}), 0);
    check("abort_framecnt_held", 32'(FrameCnt), 2);
    cyc(10);
    check("abort_stays_idle", 32'(Busy), 0);

    // Start together with Abort: Abort wins, nothing cleared
    Start = 1'b1;
    Abort = 1'b1;
    cyc(1);
    Start = 1'b0;
    Abort = 1'b0;
    check("start_abort_idle", 32'({Busy, EnExcit}), 0);
    check("start_abort_framecnt", 32'(FrameCnt), 2);
    cyc(3);
    check("start_abort_still_idle", 32'(Busy), 0);

    // No ack at all
    ack_en = 1'b0;
    MeasNum = 8'd1;
    NumFrames = 16'd1;
`ifdef SEQ_ACK_TIMEOUT_EN
    push_run(1, 1, 0);
`else
    push_req(1, 0, 0);
    push_req(3, 0, 0);
`endif
    push_done(1);
    pulse_start();
    wait_req(100);
    hi = 0;
    while (AdcReq && hi < 50) begin
      hi++;
      cyc(1);
    end
`ifdef SEQ_ACK_TIMEOUT_EN
    check("noack_req_hold", 32'(hi), 3);
`else
    check("noack_req_hold", 32'(hi), SD);
`endif
    check("noack_ackerr", 32'(AckErr), 1);
    check("noack_still_busy", 32'(Busy), 1);
    wait_done(200, n);
    cyc(1);
    check("noack_ackerr_held", 32'({AckErr, Busy}), 32'b10);

    // MeasNum=0 acts as one measurement; Start during RUN is ignored
    ack_en = 1'b1;
    MeasNum = 8'd0;
    NumFrames = 16'd2;
    push_run(1, 2, 0);
    push_done(2);
    pulse_start();
    check("start_clears_ackerr", 32'({AckErr, FrameCnt}), 0);
    wait_frame(16'd1, 200, n);
    Start = 1'b1;
    cyc(1);
    Start = 1'b0;
    wait_done(100, n);
    check("measnum0_frame_len", 32'(n + 1), 32);

    // Asynchronous reset with a request outstanding, then a clean rerun
    cyc(2);
    ack_en = 1'b0;
    MeasNum = 8'd1;
    NumFrames = 16'd0;
    push_req(1, 0, 0);
    pulse_start();
    wait_req(100);
    #2;
    Rst = 1'b0;
    #1;
    check("async_reset_outputs", 32'({EnExcit, Sync, periodCnt, AdcReq, MeasIdx, FrameCnt, Busy,
                                      Done, AckErr}), 0);
    @(negedge Clk);
    Rst = 1'b1;
    cyc(2);
    check("post_reset_idle", 32'(Busy), 0);
    ack_en = 1'b1;
    MeasNum = 8'd2;
    NumFrames = 16'd1;
    push_run(2, 1, 0);
    push_done(1);
    pulse_start();
    wait_done(200, n);
    check("rerun_done_cycles", 32'(n), 69);
    cyc(2);
    check("rerun_framecnt", 32'(FrameCnt), 1);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
